// File: rtl/lvds_rx_init_seq.sv
// LVDS receiver initialisation sequencer: PLL reset, per-channel reset release,
// DPA lock wait, FIFO/CDA reset pulses, with timeouts, bounded retry and lock supervision.
module lvds_rx_init_seq #(
  parameter int NUM_CH          = 4,
  parameter int PLL_RST_CYCLES  = 8,
  parameter int LOCK_TIMEOUT    = 1024,
  parameter int FIFO_RST_CYCLES = 2,
  parameter int CDA_RST_CYCLES  = 2,
  parameter int MAX_RETRIES     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              user_mode,
  input  logic              restart,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              rx_locked,
  input  logic [NUM_CH-1:0] rx_dpa_locked,
  output logic              pll_areset,
  output logic [NUM_CH-1:0] rx_reset,
  output logic [NUM_CH-1:0] rx_fifo_reset,
  output logic [NUM_CH-1:0] rx_cda_reset,
  output logic              init_done,
  output logic              init_error,
  output logic [3:0]        retry_cnt,
  output logic [2:0]        seq_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PLL_RST  = 3'd1;
  localparam logic [2:0] S_WAIT_PLL = 3'd2;
  localparam logic [2:0] S_WAIT_DPA = 3'd3;
  localparam logic [2:0] S_FIFO_RST = 3'd4;
  localparam logic [2:0] S_CDA_RST  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (FIFO_RST_CYCLES > CDA_RST_CYCLES) ? FIFO_RST_CYCLES : CDA_RST_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] C_ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_FIFO_LAST = CW'(FIFO_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_CDA_LAST  = CW'(CDA_RST_CYCLES - 1);
  localparam logic [3:0]    C_MAX_RETRY = 4'(MAX_RETRIES);
  localparam logic [NUM_CH-1:0] C_NO_CH = {NUM_CH{1'b0}};

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_retry;
  logic [NUM_CH-1:0] r_ch_mask;

  logic [2:0]        w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [3:0]        w_retry_nxt;
  logic              w_load_mask;
  logic [NUM_CH-1:0] w_mask_nxt;
  logic              w_dpa_ok;
  logic              w_lock_lost;
  logic [2:0]        w_rt_state;
  logic [3:0]        w_rt_retry;
  logic              w_rt_reload;

  assign w_dpa_ok    = ((rx_dpa_locked & r_ch_mask) == r_ch_mask);
  assign w_lock_lost = !rx_locked || !w_dpa_ok;

  // Retry path target: give up once the retry budget is spent, else rerun from PLL reset.
  assign w_rt_state  = (r_retry == C_MAX_RETRY) ? S_ERROR : S_PLL_RST;
  assign w_rt_retry  = (r_retry == C_MAX_RETRY) ? r_retry : (r_retry + 4'd1);
  assign w_rt_reload = (r_retry != C_MAX_RETRY);

  assign w_mask_nxt  = w_load_mask ? ch_enable : r_ch_mask;

  // Next-state, phase counter and retry bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_load_mask = 1'b0;
    if (restart && (r_state != S_IDLE)) begin
      w_state_nxt = S_PLL_RST;
      w_cnt_nxt   = C_ZERO;
      w_retry_nxt = 4'd0;
      w_load_mask = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (user_mode) begin
            w_state_nxt = S_PLL_RST;
            w_cnt_nxt   = C_ZERO;
            w_retry_nxt = 4'd0;
            w_load_mask = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PLL_RST: begin
          if (r_cnt == C_PLL_LAST) begin
            w_state_nxt = S_WAIT_PLL;
            w_cnt_nxt   = C_ZERO;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_WAIT_PLL: begin
          if (rx_locked) begin
            w_state_nxt = S_WAIT_DPA;
            w_cnt_nxt   = C_ZERO;
          end else if (r_cnt == C_TO_LAST) begin
            w_state_nxt = w_rt_state;
            w_retry_nxt = w_rt_retry;
            w_load_mask = w_rt_reload;
            w_cnt_nxt   = C_ZERO;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_WAIT_DPA: begin
          // PLL lock loss outranks a DPA lock arriving on the same cycle.
          if (!rx_locked || (!w_dpa_ok && (r_cnt == C_TO_LAST))) begin
            w_state_nxt = w_rt_state;
            w_retry_nxt = w_rt_retry;
            w_load_mask = w_rt_reload;
            w_cnt_nxt   = C_ZERO;
          end else if (w_dpa_ok) begin
            w_state_nxt = S_FIFO_RST;
            w_cnt_nxt   = C_ZERO;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_FIFO_RST: begin
          if (r_cnt == C_FIFO_LAST) begin
            w_state_nxt = S_CDA_RST;
            w_cnt_nxt   = C_ZERO;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_CDA_RST: begin
          if (r_cnt == C_CDA_LAST) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = C_ZERO;
            w_retry_nxt = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_DONE: begin
          if (w_lock_lost) begin
            w_state_nxt = w_rt_state;
            w_retry_nxt = w_rt_retry;
            w_load_mask = w_rt_reload;
            w_cnt_nxt   = C_ZERO;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        S_ERROR: begin
          w_state_nxt = S_ERROR;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = C_ZERO;
          w_retry_nxt = 4'd0;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= C_ZERO;
      r_retry   <= 4'd0;
      r_ch_mask <= C_NO_CH;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_ch_mask <= w_mask_nxt;
    end
  end

  // Output flops decoded from the next state so they switch with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_areset    <= 1'b0;
      rx_reset      <= C_NO_CH;
      rx_fifo_reset <= C_NO_CH;
      rx_cda_reset  <= C_NO_CH;
      init_done     <= 1'b0;
      init_error    <= 1'b0;
    end else begin
      pll_areset    <= (w_state_nxt == S_PLL_RST);
      rx_reset      <= ((w_state_nxt == S_PLL_RST) || (w_state_nxt == S_WAIT_PLL)) ? w_mask_nxt : C_NO_CH;
      rx_fifo_reset <= (w_state_nxt == S_FIFO_RST) ? w_mask_nxt : C_NO_CH;
      rx_cda_reset  <= (w_state_nxt == S_CDA_RST) ? w_mask_nxt : C_NO_CH;
      init_done     <= (w_state_nxt == S_DONE);
      init_error    <= (w_state_nxt == S_ERROR);
    end
  end

  assign retry_cnt = r_retry;
  assign seq_state = r_state;

endmodule
